// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its clear sequencer.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // write_hit works on fixed maximum widths so it can be shared by every
  // parameterisation; callers zero-pad their port vectors up to these sizes.
  localparam int MAX_NWR   = 8;
  localparam int MAX_AW    = 10;
  localparam int HIT_IDX_W = $clog2(MAX_NWR);

  typedef struct packed {
    logic                 hit;
    logic [HIT_IDX_W-1:0] idx;
  } wr_hit_t;

  // Highest-indexed enabled port whose address matches wins.
  function automatic wr_hit_t write_hit(
    input logic [MAX_AW-1:0]               addr,
    input logic [MAX_NWR-1:0]              wen,
    input logic [MAX_NWR-1:0][MAX_AW-1:0]  waddr
  );
    wr_hit_t r;
    r = '0;
    for (int i = 0; i < MAX_NWR; i++) begin
      if (wen[i] && (waddr[i] == addr)) begin
        r.hit = 1'b1;
        r.idx = HIT_IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write port bundle of the multi-port register file.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NWR-1:0]           wen;
  logic [NWR-1:0][AW-1:0]   waddr;
  logic [NWR-1:0][XLEN-1:0] wdata;
  logic [NRD-1:0][AW-1:0]   raddr;
  logic [NRD-1:0][XLEN-1:0] rdata;
  logic                     ready;

  modport master (
    output wen, waddr, wdata, raddr,
    input  rdata, ready
  );

  modport slave (
    input  wen, waddr, wdata, raddr,
    output rdata, ready
  );

endinterface

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: zeroes entries 1..NREGS-1 one per cycle, then raises ready.
//   state    | meaning
//   RF_CLEAR | writing 0 to entry clr_idx each cycle, external writes blocked
//   RF_READY | clear done, normal operation until the next rst
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          ready
);

  rf_state_e     state, state_nxt;
  logic [AW-1:0] clr_idx, clr_idx_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_CLEAR;
      clr_idx <= AW'(1);
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    clr_we      = 1'b0;
    ready       = 1'b0;
    case (state)
      RF_CLEAR: begin
        clr_we      = 1'b1;
        clr_idx_nxt = clr_idx + AW'(1);
        if (clr_idx == AW'(NREGS - 1)) state_nxt = RF_READY;
      end
      RF_READY: ready = 1'b1;
      default:  state_nxt = RF_CLEAR;
    endcase
  end

  assign clr_addr = clr_idx;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with optional same-cycle write bypass.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);

  localparam int AW = $clog2(NREGS);

  if (NWR > MAX_NWR || AW > MAX_AW) begin : g_size_check
    $error("regfile_mp: NWR or address width exceeds regfile_pkg limits");
  end

  logic [XLEN-1:0] regs [NREGS];
  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            ready;
  logic [NWR-1:0]  wen_eff;

  logic [MAX_NWR-1:0]             wen_pad;
  logic [MAX_NWR-1:0][MAX_AW-1:0] waddr_pad;
  logic [NRD-1:0][XLEN-1:0]       rdata_int;

  regfile_clear_seq #(.NREGS(NREGS)) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  assign wen_eff   = bus.wen & {NWR{ready}};
  assign bus.ready = ready;
  assign bus.rdata = rdata_int;

  // Later ports overwrite earlier ones in the loop, so the highest index wins.
  always_ff @(posedge clk) begin
    if (clr_we) regs[clr_addr] <= '0;
    for (int i = 0; i < NWR; i++) begin
      if (wen_eff[i] && (bus.waddr[i] != '0)) regs[bus.waddr[i]] <= bus.wdata[i];
    end
  end

  always_comb begin
    wen_pad   = '0;
    waddr_pad = '0;
    for (int i = 0; i < NWR; i++) begin
      wen_pad[i]   = wen_eff[i];
      waddr_pad[i] = MAX_AW'(bus.waddr[i]);
    end
  end

  always_comb begin
    wr_hit_t hit;
    rdata_int = '0;
    for (int r = 0; r < NRD; r++) begin
      hit = write_hit(MAX_AW'(bus.raddr[r]), wen_pad, waddr_pad);
      if (ready && (bus.raddr[r] != '0)) begin
        rdata_int[r] = regs[bus.raddr[r]];
        if ((BYPASS != 0) && hit.hit) begin
          for (int i = 0; i < NWR; i++) begin
            if (i == int'(hit.idx)) rdata_int[r] = bus.wdata[i];
          end
        end
      end
    end
  end

endmodule
